// File: rtl/idu_stage.sv
// Registered RV32I/RV32E instruction decode stage with valid/ready handshake on both sides.
// Optional RV32M decode is enabled by defining NRC_RV32M_EN.
module idu_stage #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 3,
    parameter int BXXOP_W = 3,
    parameter int MEMOP_W = 3,
    parameter int REGID_W = 5
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               ifu_valid,
    output logic               ifu_ready,
    input  logic [31:0]        ifu_inst,
    input  logic [XLEN-1:0]    ifu_pc,
    input  logic               flush,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [XLEN-1:0]    dec_pc,
    output logic [ALUOP_W-1:0] dec_alu_opcode,
    output logic [BXXOP_W-1:0] dec_bxx_opcode,
    output logic [MEMOP_W-1:0] dec_mem_opcode,
    output logic               dec_alu_sub,
    output logic               dec_alu_src1_sel_pc,
    output logic               dec_alu_src1_sel_0,
    output logic               dec_alu_src2_sel_imm,
    output logic               dec_bxx,
    output logic               dec_jump,
    output logic               dec_mem_read,
    output logic               dec_mem_write,
    output logic               dec_ebreak,
    output logic               dec_rd_write,
    output logic               dec_muldiv,
    output logic               dec_illegal,
    output logic [REGID_W-1:0] dec_rd_addr,
    output logic [REGID_W-1:0] dec_rs1_addr,
    output logic [REGID_W-1:0] dec_rs2_addr,
    output logic [XLEN-1:0]    dec_imm
);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_BRANCH = 7'b1100011,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    logic [6:0]         opc;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [4:0]         rd_f, rs1_f, rs2_f;
    logic signed [31:0] imm_c;
    logic               illegal_c, use_rd, use_rs1, use_rs2, muldiv_c;
    logic               is_op, is_opimm;
    logic               accept;

    assign opc      = ifu_inst[6:0];
    assign funct3   = ifu_inst[14:12];
    assign funct7   = ifu_inst[31:25];
    assign rd_f     = ifu_inst[11:7];
    assign rs1_f    = ifu_inst[19:15];
    assign rs2_f    = ifu_inst[24:20];
    assign is_op    = (opc == OPC_OP);
    assign is_opimm = (opc == OPC_OPIMM);

    always_comb begin
        imm_c     = '0;
        illegal_c = 1'b0;
        use_rd    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        muldiv_c  = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                imm_c  = {ifu_inst[31:12], 12'b0};
                use_rd = 1'b1;
            end
            OPC_JAL: begin
                imm_c  = {{11{ifu_inst[31]}}, ifu_inst[31], ifu_inst[19:12], ifu_inst[20],
                          ifu_inst[30:21], 1'b0};
                use_rd = 1'b1;
            end
            OPC_JALR: begin
                imm_c     = {{20{ifu_inst[31]}}, ifu_inst[31:20]};
                use_rd    = 1'b1;
                use_rs1   = 1'b1;
                illegal_c = (funct3 != 3'd0);
            end
            OPC_LOAD: begin
                imm_c     = {{20{ifu_inst[31]}}, ifu_inst[31:20]};
                use_rd    = 1'b1;
                use_rs1   = 1'b1;
                illegal_c = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            end
            OPC_STORE: begin
                imm_c     = {{20{ifu_inst[31]}}, ifu_inst[31:25], ifu_inst[11:7]};
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                illegal_c = (funct3 >= 3'd3);
            end
            OPC_OPIMM: begin
                imm_c   = {{20{ifu_inst[31]}}, ifu_inst[31:20]};
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                // Shift immediates reuse the funct7 slot as a qualifier
                if (funct3 == 3'd1)
                    illegal_c = (funct7 != 7'h00);
                else if (funct3 == 3'd5)
                    illegal_c = (funct7 != 7'h00) && (funct7 != 7'h20);
            end
            OPC_OP: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                case (funct7)
                    7'h00:   illegal_c = 1'b0;
                    7'h20:   illegal_c = (funct3 != 3'd0) && (funct3 != 3'd5);
`ifdef NRC_RV32M_EN
                    7'h01:   muldiv_c  = 1'b1;
`endif
                    default: illegal_c = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                imm_c     = {{19{ifu_inst[31]}}, ifu_inst[31], ifu_inst[7], ifu_inst[30:25],
                             ifu_inst[11:8], 1'b0};
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                illegal_c = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            OPC_SYSTEM: illegal_c = (ifu_inst != INST_EBREAK);
            default:    illegal_c = 1'b1;
        endcase
        // Narrow register files reject any referenced index beyond their range
        if (REGID_W < 5) begin
            if ((use_rd  && ((rd_f  >> REGID_W) != 5'd0)) ||
                (use_rs1 && ((rs1_f >> REGID_W) != 5'd0)) ||
                (use_rs2 && ((rs2_f >> REGID_W) != 5'd0)))
                illegal_c = 1'b1;
        end
    end

    assign ifu_ready = ~dec_valid | dec_ready | flush;
    assign accept    = ifu_valid & ifu_ready & ~flush;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            dec_valid            <= 1'b0;
            dec_pc               <= '0;
            dec_alu_opcode       <= '0;
            dec_bxx_opcode       <= '0;
            dec_mem_opcode       <= '0;
            dec_alu_sub          <= 1'b0;
            dec_alu_src1_sel_pc  <= 1'b0;
            dec_alu_src1_sel_0   <= 1'b0;
            dec_alu_src2_sel_imm <= 1'b0;
            dec_bxx              <= 1'b0;
            dec_jump             <= 1'b0;
            dec_mem_read         <= 1'b0;
            dec_mem_write        <= 1'b0;
            dec_ebreak           <= 1'b0;
            dec_rd_write         <= 1'b0;
            dec_muldiv           <= 1'b0;
            dec_illegal          <= 1'b0;
            dec_rd_addr          <= '0;
            dec_rs1_addr         <= '0;
            dec_rs2_addr         <= '0;
            dec_imm              <= '0;
        end else if (flush) begin
            dec_valid <= 1'b0;
        end else if (accept) begin
            dec_valid            <= 1'b1;
            dec_pc               <= ifu_pc;
            dec_alu_opcode       <= ALUOP_W'(funct3);
            dec_bxx_opcode       <= BXXOP_W'(funct3);
            dec_mem_opcode       <= MEMOP_W'(funct3);
            dec_alu_sub          <= (funct7 == 7'h20) && (is_op || (is_opimm && funct3 == 3'd5));
            dec_alu_src1_sel_pc  <= (opc == OPC_JAL) || (opc == OPC_JALR) ||
                                    (opc == OPC_AUIPC) || (opc == OPC_BRANCH);
            dec_alu_src1_sel_0   <= (opc == OPC_LUI);
            dec_alu_src2_sel_imm <= ~is_op;
            dec_bxx              <= (opc == OPC_BRANCH) & ~illegal_c;
            dec_jump             <= ((opc == OPC_JAL) || (opc == OPC_JALR)) & ~illegal_c;
            dec_mem_read         <= (opc == OPC_LOAD) & ~illegal_c;
            dec_mem_write        <= (opc == OPC_STORE) & ~illegal_c;
            dec_ebreak           <= (ifu_inst == INST_EBREAK) & ~illegal_c;
            dec_rd_write         <= use_rd & (rd_f != 5'd0) & ~illegal_c;
            dec_muldiv           <= muldiv_c & ~illegal_c;
            dec_illegal          <= illegal_c;
            dec_rd_addr          <= REGID_W'(rd_f);
            dec_rs1_addr         <= REGID_W'(rs1_f);
            dec_rs2_addr         <= REGID_W'(rs2_f);
            dec_imm              <= XLEN'(imm_c);
        end else if (dec_ready) begin
            dec_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_idu_stage.sv
// Self-checking bench for idu_stage: RV32I and RV32E instances against an in-bench decode model.
module tb_idu_stage;

`ifdef NRC_RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  alu;
        logic [2:0]  bxxop;
        logic [2:0]  memop;
        logic sub, s1pc, s10, s2imm, bxx, jump, mrd, mwr, ebreak, rdw, muldiv, illegal;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        ifu_valid, flush, dec_ready;
    logic [31:0] ifu_inst, ifu_pc;

    logic        r5, v5, re, ve;
    logic [31:0] d5_pc, d5_imm, de_pc, de_imm;
    logic [2:0]  d5_alu, d5_bxxop, d5_memop, de_alu, de_bxxop, de_memop;
    logic d5_sub, d5_s1pc, d5_s10, d5_s2imm, d5_bxx, d5_jump, d5_mrd, d5_mwr, d5_ebreak, d5_rdw,
          d5_muldiv, d5_illegal;
    logic de_sub, de_s1pc, de_s10, de_s2imm, de_bxx, de_jump, de_mrd, de_mwr, de_ebreak, de_rdw,
          de_muldiv, de_illegal;
    logic [4:0]  d5_rd, d5_rs1, d5_rs2;
    logic [3:0]  de_rd, de_rs1, de_rs2;
    bundle_t     act5, acte;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    idu_stage u_dut (
        .clk(clk), .rst_b(rst_b), .ifu_valid(ifu_valid), .ifu_ready(r5), .ifu_inst(ifu_inst),
        .ifu_pc(ifu_pc), .flush(flush), .dec_valid(v5), .dec_ready(dec_ready), .dec_pc(d5_pc),
        .dec_alu_opcode(d5_alu), .dec_bxx_opcode(d5_bxxop), .dec_mem_opcode(d5_memop),
        .dec_alu_sub(d5_sub), .dec_alu_src1_sel_pc(d5_s1pc), .dec_alu_src1_sel_0(d5_s10),
        .dec_alu_src2_sel_imm(d5_s2imm), .dec_bxx(d5_bxx), .dec_jump(d5_jump),
        .dec_mem_read(d5_mrd), .dec_mem_write(d5_mwr), .dec_ebreak(d5_ebreak),
        .dec_rd_write(d5_rdw), .dec_muldiv(d5_muldiv), .dec_illegal(d5_illegal),
        .dec_rd_addr(d5_rd), .dec_rs1_addr(d5_rs1), .dec_rs2_addr(d5_rs2), .dec_imm(d5_imm)
    );

    idu_stage #(.REGID_W(4)) u_dut_e (
        .clk(clk), .rst_b(rst_b), .ifu_valid(ifu_valid), .ifu_ready(re), .ifu_inst(ifu_inst),
        .ifu_pc(ifu_pc), .flush(flush), .dec_valid(ve), .dec_ready(dec_ready), .dec_pc(de_pc),
        .dec_alu_opcode(de_alu), .dec_bxx_opcode(de_bxxop), .dec_mem_opcode(de_memop),
        .dec_alu_sub(de_sub), .dec_alu_src1_sel_pc(de_s1pc), .dec_alu_src1_sel_0(de_s10),
        .dec_alu_src2_sel_imm(de_s2imm), .dec_bxx(de_bxx), .dec_jump(de_jump),
        .dec_mem_read(de_mrd), .dec_mem_write(de_mwr), .dec_ebreak(de_ebreak),
        .dec_rd_write(de_rdw), .dec_muldiv(de_muldiv), .dec_illegal(de_illegal),
        .dec_rd_addr(de_rd), .dec_rs1_addr(de_rs1), .dec_rs2_addr(de_rs2), .dec_imm(de_imm)
    );

    assign act5 = {d5_pc, d5_alu, d5_bxxop, d5_memop, d5_sub, d5_s1pc, d5_s10, d5_s2imm, d5_bxx,
                   d5_jump, d5_mrd, d5_mwr, d5_ebreak, d5_rdw, d5_muldiv, d5_illegal,
                   d5_rd, d5_rs1, d5_rs2, d5_imm};
    assign acte = {de_pc, de_alu, de_bxxop, de_memop, de_sub, de_s1pc, de_s10, de_s2imm, de_bxx,
                   de_jump, de_mrd, de_mwr, de_ebreak, de_rdw, de_muldiv, de_illegal,
                   {1'b0, de_rd}, {1'b0, de_rs1}, {1'b0, de_rs2}, de_imm};

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Reference decode straight from the ISA rules: classify format, then legality, then fields.
    function automatic bundle_t ref_decode(input logic [31:0] i, input logic [31:0] pc, input int rw);
        bundle_t    b;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [4:0] rd, rs1, rs2;
        bit         badi, rd_u, rs1_u, rs2_u;
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        rd = i[11:7]; rs1 = i[19:15]; rs2 = i[24:20];
        b = '0;
        case (op)
            7'h37, 7'h17, 7'h6F: badi = 1'b0;
            7'h67: badi = (f3 != 0);
            7'h03: badi = (f3 == 3) || (f3 == 6) || (f3 == 7);
            7'h23: badi = (f3 >= 3);
            7'h13: badi = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 == 0 || f7 == 7'h20));
            7'h33: badi = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (M_EN && f7 == 1));
            7'h63: badi = (f3 == 2) || (f3 == 3);
            7'h73: badi = (i != 32'h00100073);
            default: badi = 1'b1;
        endcase
        rd_u  = op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33};
        rs1_u = op inside {7'h67, 7'h03, 7'h23, 7'h13, 7'h33, 7'h63};
        rs2_u = op inside {7'h23, 7'h33, 7'h63};
        if (rw == 4 && ((rd_u && rd[4]) || (rs1_u && rs1[4]) || (rs2_u && rs2[4]))) badi = 1'b1;
        case (op)
            7'h37, 7'h17: b.imm = {i[31:12], 12'h000};
            7'h6F: b.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            7'h67, 7'h03, 7'h13: b.imm = {{20{i[31]}}, i[31:20]};
            7'h23: b.imm = {{20{i[31]}}, i[31:25], i[11:7]};
            7'h63: b.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: b.imm = 32'h0;
        endcase
        b.pc      = pc;
        b.alu     = f3;
        b.bxxop   = f3;
        b.memop   = f3;
        b.sub     = (f7 == 7'h20) && (op == 7'h33 || (op == 7'h13 && f3 == 5));
        b.s1pc    = op inside {7'h6F, 7'h67, 7'h17, 7'h63};
        b.s10     = (op == 7'h37);
        b.s2imm   = (op != 7'h33);
        b.bxx     = (op == 7'h63) && !badi;
        b.jump    = (op == 7'h6F || op == 7'h67) && !badi;
        b.mrd     = (op == 7'h03) && !badi;
        b.mwr     = (op == 7'h23) && !badi;
        b.ebreak  = (i == 32'h00100073);
        b.rdw     = rd_u && rd != 0 && !badi;
        b.muldiv  = M_EN && op == 7'h33 && f7 == 1 && !badi;
        b.illegal = badi;
        b.rd      = (rw == 4) ? {1'b0, rd[3:0]}  : rd;
        b.rs1     = (rw == 4) ? {1'b0, rs1[3:0]} : rs1;
        b.rs2     = (rw == 4) ? {1'b0, rs2[3:0]} : rs2;
        return b;
    endfunction

    bit      m_valid = 1'b0;
    bundle_t m5 = '0;
    bundle_t me = '0;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_valid = 1'b0;
            m5 = '0;
            me = '0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (ifu_valid && (!m_valid || dec_ready)) begin
            m5 = ref_decode(ifu_inst, ifu_pc, 5);
            me = ref_decode(ifu_inst, ifu_pc, 4);
            m_valid = 1'b1;
        end else if (dec_ready) begin
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        check("valid5", {127'd0, v5}, {127'd0, m_valid});
        check("ready5", {127'd0, r5}, {127'd0, (!m_valid || dec_ready || flush)});
        check("bundle5", {28'd0, act5}, {28'd0, m5});
        check("valid_e", {127'd0, ve}, {127'd0, m_valid});
        check("ready_e", {127'd0, re}, {127'd0, (!m_valid || dec_ready || flush)});
        check("bundle_e", {28'd0, acte}, {28'd0, me});
    end

    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h13, 7'h33, 7'h63, 7'h73};

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        int unsigned k;
        r = $urandom;
        k = $urandom_range(0, 11);
        if (k < 10) begin
            r[6:0] = ops[k];
            if (ops[k] == 7'h33) begin
                case ($urandom_range(0, 3))
                    0: r[31:25] = 7'h00;
                    1: r[31:25] = 7'h20;
                    2: r[31:25] = 7'h01;
                    default: ;
                endcase
            end else if (ops[k] == 7'h13 && $urandom_range(0, 1) == 1) begin
                r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end else if (ops[k] == 7'h73 && $urandom_range(0, 1) == 1) begin
                r = 32'h00100073;
            end
        end else if (k == 11) begin
            r = 32'h00100073;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ifu_valid = 1'b0; ifu_inst = '0; ifu_pc = '0; flush = 1'b0; dec_ready = 1'b0;
        #1 rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1;
        check("rst_valid", {127'd0, v5}, 128'd0);
        check("rst_ready", {127'd0, r5}, 128'd1);
        check("rst_imm", {96'd0, d5_imm}, 128'd0);
        check("rst_pc", {96'd0, d5_pc}, 128'd0);

        ifu_valid = 1'b1; ifu_inst = 32'hFFF10093; ifu_pc = 32'h80000000; dec_ready = 1'b1;
        step();
        check("addi_valid", {127'd0, v5}, 128'd1);
        check("addi_imm", {96'd0, d5_imm}, 128'hFFFFFFFF);
        check("addi_rd", {123'd0, d5_rd}, 128'd1);
        check("addi_rs1", {123'd0, d5_rs1}, 128'd2);
        check("addi_s2imm", {127'd0, d5_s2imm}, 128'd1);
        check("addi_rdw", {127'd0, d5_rdw}, 128'd1);
        check("addi_pc", {96'd0, d5_pc}, 128'h80000000);

        ifu_inst = 32'h405201B3; ifu_pc = 32'h80000004;
        step();
        check("sub_sub", {127'd0, d5_sub}, 128'd1);
        check("sub_s2imm", {127'd0, d5_s2imm}, 128'd0);

        ifu_inst = 32'hFE208EE3; ifu_pc = 32'h80000008;
        step();
        check("beq_bxx", {127'd0, d5_bxx}, 128'd1);
        check("beq_imm", {96'd0, d5_imm}, 128'hFFFFFFFC);
        check("beq_s1pc", {127'd0, d5_s1pc}, 128'd1);
        check("beq_rdw", {127'd0, d5_rdw}, 128'd0);

        ifu_inst = 32'h00100073; ifu_pc = 32'h8000000C;
        step();
        dec_ready = 1'b0; ifu_inst = 32'hFFF10093; ifu_pc = 32'h80000010;
        #1;
        check("stall_ready0", {127'd0, r5}, 128'd0);
        repeat (3) begin
            step();
            check("stall_ebreak", {127'd0, d5_ebreak}, 128'd1);
            check("stall_ready", {127'd0, r5}, 128'd0);
        end
        dec_ready = 1'b1;
        #1;
        check("release_ready", {127'd0, r5}, 128'd1);
        step();
        check("release_pc", {96'd0, d5_pc}, 128'h80000010);
        check("release_ebreak", {127'd0, d5_ebreak}, 128'd0);

        flush = 1'b1; dec_ready = 1'b0; ifu_inst = 32'h000012B7; ifu_pc = 32'h00001234;
        step();
        flush = 1'b0; ifu_valid = 1'b0;
        check("flush_valid", {127'd0, v5}, 128'd0);
        check("flush_pc_kept", {96'd0, d5_pc}, 128'h80000010);
        step();
        check("flush_idle", {127'd0, v5}, 128'd0);

        ifu_valid = 1'b1; ifu_inst = 32'h023100B3; ifu_pc = 32'h00002000; dec_ready = 1'b1;
        step();
        ifu_valid = 1'b0;
`ifdef NRC_RV32M_EN
        check("mul_muldiv", {127'd0, d5_muldiv}, 128'd1);
        check("mul_illegal", {127'd0, d5_illegal}, 128'd0);
`else
        check("mul_illegal", {127'd0, d5_illegal}, 128'd1);
        check("mul_rdw", {127'd0, d5_rdw}, 128'd0);
`endif

        ifu_valid = 1'b1; ifu_inst = 32'h00208833; ifu_pc = 32'h00002004;
        step();
        ifu_valid = 1'b0;
        check("e_illegal", {127'd0, de_illegal}, 128'd1);
        check("e_rdw", {127'd0, de_rdw}, 128'd0);
        check("i_illegal", {127'd0, d5_illegal}, 128'd0);
        check("i_rdw", {127'd0, d5_rdw}, 128'd1);

        ifu_valid = 1'b1; ifu_inst = 32'hFFF10093; ifu_pc = 32'h00003000; dec_ready = 1'b0;
        step();
        ifu_valid = 1'b0;
        step();
        check("prerst_valid", {127'd0, v5}, 128'd1);
        rst_b = 1'b0;
        #1;
        check("midrst_valid", {127'd0, v5}, 128'd0);
        check("midrst_valid_e", {127'd0, ve}, 128'd0);
        check("midrst_pc", {96'd0, d5_pc}, 128'd0);
        check("midrst_ready", {127'd0, r5}, 128'd1);
        #2 rst_b = 1'b1;

        repeat (3000) begin
            step();
            ifu_valid = ($urandom_range(0, 3) != 0);
            dec_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            ifu_pc    = $urandom;
            ifu_inst  = rand_inst();
        end
        ifu_valid = 1'b0; flush = 1'b0; dec_ready = 1'b1;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
